// File: rtl/mem_wb_unit.sv
// Memory/writeback stage: accepts one execute result, performs an optional single
// data-memory access with a cycle timeout, then writes the register file once.
module mem_wb_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_read_mm,
   input  logic        ex_write_mm,
   input  logic [31:0] ex_mm_addr,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_write_r,
   input  logic        ex_write_en,
   input  logic [31:0] ex_write_data,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        wb_en,
   output logic [4:0]  wb_r,
   output logic [31:0] wb_data,
   output logic        align_err,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   state_t      r_state;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [4:0]  r_wr;
   logic        r_wen;
   logic [7:0]  r_cnt;
   logic        r_wb_en;
   logic [31:0] r_wb_data;
   logic        r_align_err;
   logic        r_timeout_err;

   logic        w_bad_mem;
   logic        w_is_mem;
   logic [7:0]  w_cnt_nxt;

   assign w_is_mem  = ex_read_mm | ex_write_mm;
   assign w_bad_mem = (ex_read_mm & ex_write_mm) | (ex_mm_addr[1:0] != 2'b00);
   assign w_cnt_nxt = r_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_req         <= 1'b0;
         r_we          <= 1'b0;
         r_addr        <= 32'h0;
         r_wdata       <= 32'h0;
         r_wr          <= 5'd0;
         r_wen         <= 1'b0;
         r_cnt         <= 8'd0;
         r_wb_en       <= 1'b0;
         r_wb_data     <= 32'h0;
         r_align_err   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         // Pulses last one cycle unless re-armed below.
         r_wb_en       <= 1'b0;
         r_align_err   <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ex_valid) begin
                  r_wr    <= ex_write_r;
                  r_wen   <= ex_write_en;
                  r_we    <= ex_write_mm;
                  r_addr  <= {ex_mm_addr[31:2], 2'b00};
                  r_wdata <= ex_store_data;
                  r_cnt   <= 8'd0;
                  if (!w_is_mem) begin
                     r_wb_data <= ex_write_data;
                     r_wb_en   <= ex_write_en & (ex_write_r != 5'd0);
                     r_state   <= WB;
                  end else if (w_bad_mem) begin
                     r_align_err <= 1'b1;
                  end else begin
                     r_req   <= 1'b1;
                     r_state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               // An ack in the final allowed cycle still completes the op.
               if (dm_ack) begin
                  r_req <= 1'b0;
                  if (!r_we) begin
                     r_wb_data <= dm_rdata;
                  end
                  r_wb_en <= r_wen & (r_wr != 5'd0) & ~r_we;
                  r_state <= WB;
               end else if (w_cnt_nxt == TimeoutCnt) begin
                  r_req         <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_state       <= IDLE;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            WB: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ex_ready    = (r_state == IDLE);
   assign dm_req      = r_req;
   assign dm_we       = r_we;
   assign dm_addr     = r_addr;
   assign dm_wdata    = r_wdata;
   assign wb_en       = r_wb_en;
   assign wb_r        = r_wr;
   assign wb_data     = r_wb_data;
   assign align_err   = r_align_err;
   assign timeout_err = r_timeout_err;

endmodule

// File: doc/mem_wb_unit.md
MEM_WB_UNIT -- requirements
Module: mem_wb_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent in ACCESS waiting for dm_ack (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port ex_valid, input, 1, execute-stage result valid.
REQ-005 SHALL have port ex_ready, output, 1, unit able to accept an execute result.
REQ-006 SHALL have port ex_read_mm, input, 1, load request.
REQ-007 SHALL have port ex_write_mm, input, 1, store request.
REQ-008 SHALL have port ex_mm_addr, input, 32, data-memory byte address.
REQ-009 SHALL have port ex_store_data, input, 32, store data.
REQ-010 SHALL have port ex_write_r, input, 5, destination register number.
REQ-011 SHALL have port ex_write_en, input, 1, register write requested.
REQ-012 SHALL have port ex_write_data, input, 32, ALU result for non-memory ops.
REQ-013 SHALL have port dm_req, output, 1, data-memory request.
REQ-014 SHALL have port dm_we, output, 1, 1 = store, 0 = load.
REQ-015 SHALL have port dm_addr, output, 32, memory word address (byte address, bits [1:0] = 0).
REQ-016 SHALL have port dm_wdata, output, 32, store data.
REQ-017 SHALL have port dm_ack, input, 1, memory completion (single-cycle pulse).
REQ-018 SHALL have port dm_rdata, input, 32, load data, valid while dm_ack = 1.
REQ-019 SHALL have ports wb_en (output, 1), wb_r (output, 5) and wb_data (output, 32), forming the register-file write port.
REQ-020 SHALL have ports align_err (output, 1) and timeout_err (output, 1), each a one-cycle error pulse.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS and WB; ex_ready = 1 only in IDLE.
REQ-022 SHALL accept a transfer when ex_valid = 1 and ex_ready = 1, registering all ex_* inputs on that edge.
REQ-023 SHALL, for an accepted op with read_mm = write_mm = 0, go IDLE -> WB; wb_en asserts on the cycle after acceptance.
REQ-024 SHALL, for an accepted op with exactly one of read_mm/write_mm set and addr[1:0] = 00, go IDLE -> ACCESS with dm_req = 1 from the next cycle.
REQ-025 SHALL hold dm_req, dm_we, dm_addr and dm_wdata stable throughout ACCESS until the cycle dm_ack = 1 is sampled.
REQ-026 SHALL, on dm_ack in ACCESS, drop dm_req on the next cycle, capture dm_rdata for loads, and go to WB.
REQ-027 SHALL, in WB, drive wb_en for exactly one cycle, then return to IDLE.
REQ-028 SHALL set wb_en = captured write_en AND (write_r != 0) AND NOT store.
REQ-029 SHALL drive wb_data = captured dm_rdata for loads and captured ex_write_data for non-memory ops.
REQ-030 SHALL drive wb_r = captured write_r.
REQ-031 SHALL treat a misaligned address (addr[1:0] != 00), or read_mm = write_mm = 1, as an error: issue no dm_req, pulse align_err one cycle after acceptance, perform no writeback, and remain in IDLE.
REQ-032 SHALL count ACCESS cycles with an 8-bit counter cleared on ACCESS entry.
REQ-033 SHALL, when the count reaches TIMEOUT with no dm_ack, deassert dm_req, pulse timeout_err for one cycle, suppress writeback, and go to IDLE.
REQ-034 SHALL give dm_ack priority over timeout when both occur in the same cycle.
REQ-035 SHALL ignore dm_ack outside ACCESS.
REQ-036 SHALL achieve a throughput of at most one op per 2 cycles (non-memory) or per 3 + wait cycles (memory).

Reset
REQ-037 SHALL, on rst, enter IDLE and drive all outputs to 0 except ex_ready = 1 on the following cycle.
REQ-038 SHALL, on rst in any state (including ACCESS mid-request), abandon the op: no wb_en and no error pulse; dm_req = 0 from the next edge.

Verification
REQ-039 SHALL cover: ALU op (write_r = 5, write_data = 0x1234, en = 1) -> wb_en = 1, wb_r = 5, wb_data = 0x1234 one cycle after acceptance.
REQ-040 SHALL cover: load at addr 0x100, dm_ack after 3 cycles with rdata 0xDEADBEEF, write_r = 8 -> dm_req high for 3 cycles, then wb_data = 0xDEADBEEF, wb_r = 8.
REQ-041 SHALL cover: store at addr 0x204 with data 0xA5A5A5A5 -> dm_we = 1, dm_wdata = 0xA5A5A5A5, no wb_en.
REQ-042 SHALL cover: load at addr 0x102 -> align_err pulse, dm_req stays 0, no wb_en; and load to write_r = 0 -> no wb_en.
REQ-043 SHALL cover: TIMEOUT = 4 with dm_ack never asserted -> dm_req high 4 cycles, timeout_err pulse, return to IDLE; and dm_ack arriving on cycle 4 -> normal writeback with no error.
REQ-044 SHALL cover: rst asserted during ACCESS -> dm_req = 0 next cycle, no wb_en, ex_ready = 1 after reset.
